user_wb_port_regs: RTL and testbench

- Wishbone-slave register block in the user project area, reached through the management SoC's Wishbone port.
- Firmware booted from SPI flash writes 16-bit status "checkbits" to the chip pads mprj_io[31:16]:
  - 0xAB60 when the Wishbone test starts.
  - 0xAB6A when it passes.
- Also provides pad output-enable control, a synchronized pad-input view, scratch registers and a read-only ID for bus read/write checks.

---
 rtl/user_wb_port_pkg.sv | 31 +++
 rtl/user_wb_port_regs_sync2.sv | 26 ++
 rtl/user_wb_port_regs.sv | 129 ++++++++++++
 tb/tb_user_wb_port_regs.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_wb_port_pkg.sv
// Shared constants and helpers for the user-area Wishbone register block.
//   - Register byte offsets within the 256-byte window decoded by the block.
//   - Reset values of the writable registers.
//   - byte_merge(): applies a Wishbone byte-lane-masked write to an old value.
package user_wb_port_pkg;

    localparam logic [7:0] OFF_CHECK    = 8'h00;
    localparam logic [7:0] OFF_OEB      = 8'h04;
    localparam logic [7:0] OFF_PADIN    = 8'h08;
    localparam logic [7:0] OFF_SCRATCH0 = 8'h0C;
    localparam logic [7:0] OFF_SCRATCH1 = 8'h10;
    localparam logic [7:0] OFF_SCRATCH2 = 8'h14;
    localparam logic [7:0] OFF_SCRATCH3 = 8'h18;
    localparam logic [7:0] OFF_ID       = 8'h1C;

    localparam logic [15:0] CHECK_RST   = 16'h0000;
    localparam logic [31:0] SCRATCH_RST = 32'h0000_0000;

    // Byte b of the result comes from new_val when sel[b] is set, else from old_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/user_wb_port_regs_sync2.sv
// Two-flop synchronizer for a bus of asynchronous pad inputs.
// Ports: clk, rst (async, active high), d (async input), q (synchronized).
// Each bit is synchronized independently; multi-bit values are not coherent
// while they are changing.
module user_wb_port_sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/user_wb_port_regs.sv
// Wishbone slave register block for the user project area.
// Holds the CHECK word driven onto mprj_io[31:16], the pad output-enable-bar,
// a synchronized view of the pad inputs, four scratch words and a fixed ID.
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   wbs_cyc/stb/we/sel/adr/dat  Wishbone slave request
//   wbs_ack_o, wbs_dat_o        single-cycle ack, read data (0 outside ack)
//   wbs_err_o                   only with USER_WB_PORT_ERR_EN: error response
//                               for unmapped addresses and writes to RO regs
//   io_in, io_out, io_oeb       pad input, CHECK output, output-enable-bar
module user_wb_port_regs
    import user_wb_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE = 32'h5249_5343,
    parameter logic [15:0] OEB_RST  = 16'hFFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
`ifdef USER_WB_PORT_ERR_EN
    output logic        wbs_err_o,
`endif
    output logic [31:0] wbs_dat_o,
    input  logic [15:0] io_in,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb
);

    logic [15:0]      check_q;
    logic [15:0]      oeb_q;
    logic [3:0][31:0] scratch_q;
    logic [15:0]      padin;
    logic [7:0]       off;
    logic             hit;
    logic             mapped;
    logic             ro;
    logic             req;
    logic [31:0]      rdata;
    logic [1:0]       unused_adr;

    assign unused_adr = wbs_adr_i[1:0];
    assign off        = {wbs_adr_i[7:2], 2'b00};
    assign hit        = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign io_out     = check_q;
    assign io_oeb     = oeb_q;

    // Excluding cycles where a response is already out makes a held strobe
    // produce one transfer every two cycles.
`ifdef USER_WB_PORT_ERR_EN
    assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
`else
    assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
`endif

    user_wb_port_sync2 #(.WIDTH(16)) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (io_in),
        .q   (padin)
    );

    always_comb begin
        rdata  = '0;
        mapped = hit;
        ro     = 1'b0;
        if (hit) begin
            case (off)
                OFF_CHECK:    rdata = {16'h0000, check_q};
                OFF_OEB:      rdata = {16'h0000, oeb_q};
                OFF_PADIN:    begin rdata = {16'h0000, padin}; ro = 1'b1; end
                OFF_SCRATCH0: rdata = scratch_q[0];
                OFF_SCRATCH1: rdata = scratch_q[1];
                OFF_SCRATCH2: rdata = scratch_q[2];
                OFF_SCRATCH3: rdata = scratch_q[3];
                OFF_ID:       begin rdata = ID_VALUE; ro = 1'b1; end
                default:      mapped = 1'b0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
`ifdef USER_WB_PORT_ERR_EN
            wbs_err_o <= 1'b0;
`endif
            wbs_dat_o <= '0;
            check_q   <= CHECK_RST;
            oeb_q     <= OEB_RST;
            scratch_q <= {4{SCRATCH_RST}};
        end else begin
            wbs_ack_o <= 1'b0;
`ifdef USER_WB_PORT_ERR_EN
            wbs_err_o <= 1'b0;
`endif
            wbs_dat_o <= '0;
            if (req) begin
`ifdef USER_WB_PORT_ERR_EN
                if (!mapped || (wbs_we_i && ro)) wbs_err_o <= 1'b1;
                else
`endif
                begin
                    wbs_ack_o <= 1'b1;
                    if (!wbs_we_i) begin
                        wbs_dat_o <= rdata;
                    end else if (hit) begin
                        case (off)
                            OFF_CHECK:    check_q <= 16'(byte_merge({16'h0000, check_q}, wbs_dat_i, wbs_sel_i));
                            OFF_OEB:      oeb_q   <= 16'(byte_merge({16'h0000, oeb_q}, wbs_dat_i, wbs_sel_i));
                            OFF_SCRATCH0: scratch_q[0] <= byte_merge(scratch_q[0], wbs_dat_i, wbs_sel_i);
                            OFF_SCRATCH1: scratch_q[1] <= byte_merge(scratch_q[1], wbs_dat_i, wbs_sel_i);
                            OFF_SCRATCH2: scratch_q[2] <= byte_merge(scratch_q[2], wbs_dat_i, wbs_sel_i);
                            OFF_SCRATCH3: scratch_q[3] <= byte_merge(scratch_q[3], wbs_dat_i, wbs_sel_i);
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_user_wb_port_regs.sv
module tb_user_wb_port_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] IDV  = 32'h5249_5343;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic        err;
    logic [31:0] rdat_o;
    logic [15:0] io_in = '0;
    logic [15:0] io_out, io_oeb;

    int checks = 0;
    int errors = 0;

    // Reference state: what firmware would expect the registers to hold.
    logic [15:0] m_check, m_oeb;
    logic [31:0] m_scr [4];

    always #5 clk = ~clk;

    user_wb_port_regs dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
`ifdef USER_WB_PORT_ERR_EN
        .wbs_err_o (err),
`endif
        .wbs_dat_o (rdat_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

`ifndef USER_WB_PORT_ERR_EN
    assign err = 1'b0;
`endif

    function automatic void m_reset();
        m_check = 16'h0000;
        m_oeb   = 16'hFFFF;
        for (int i = 0; i < 4; i++) m_scr[i] = 32'h0;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic int m_index(input logic [31:0] a);
        if (a[31:8] != BASE[31:8]) return -1;
        if (a[7:0] > 8'h1F) return -1;
        return int'(a[7:2]);   // 0 CHECK, 1 OEB, 2 PADIN, 3..6 SCRATCH, 7 ID
    endfunction

    function automatic logic m_err(input logic w, input logic [31:0] a);
`ifdef USER_WB_PORT_ERR_EN
        int i;
        i = m_index(a);
        return (i < 0) || (w && (i == 2 || i == 7));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [15:0] pad);
        int i;
        i = m_index(a);
        if (i == 0) return {16'h0, m_check};
        if (i == 1) return {16'h0, m_oeb};
        if (i == 2) return {16'h0, pad};
        if (i >= 3 && i <= 6) return m_scr[i-3];
        if (i == 7) return IDV;
        return 32'h0;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int i;
        i = m_index(a);
        if (i == 0) m_check = lanes({16'h0, m_check}, d, s) & 32'hFFFF;
        if (i == 1) m_oeb   = lanes({16'h0, m_oeb}, d, s) & 32'hFFFF;
        if (i >= 3 && i <= 6) m_scr[i-3] = lanes(m_scr[i-3], d, s);
    endfunction

    // One Wishbone transfer. Reports cycles to response, the response kind,
    // the data seen with it, and whether the response line dropped a cycle later.
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd, output int lat,
                       output logic ak, output logic er, output logic dropped);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        lat = -1; rd = '0; ak = 1'b0; er = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                lat = n; rd = rdat_o; ak = ack; er = err;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        dropped = !ack && !err;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat; logic ak, er, dr;
        @(posedge clk); #3;
        rst = 1'b1;
        m_reset();
        #1;
        checks++; if (io_out !== 16'h0000) begin errors++; $display("FAIL reset_io_out got %h exp 0000", io_out); end
        checks++; if (io_oeb !== 16'hFFFF) begin errors++; $display("FAIL reset_io_oeb got %h exp ffff", io_oeb); end
        checks++; if (ack !== 1'b0 || rdat_o !== 32'h0) begin errors++; $display("FAIL reset_ack got %b/%h exp 0/0", ack, rdat_o); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus(1'b0, BASE + 32'h1C, 4'hF, 32'h0, rd, lat, ak, er, dr);
        checks++; if (lat !== 1 || !ak || rd !== IDV) begin errors++; $display("FAIL reset_id got lat %0d data %h exp lat 1 data %h", lat, rd, IDV); end
    endtask

    task automatic test_check();
        logic [31:0] rd; int lat; logic ak, er, dr;
        bus(1'b1, BASE, 4'hF, 32'h0000_AB60, rd, lat, ak, er, dr);
        m_write(BASE, 4'hF, 32'h0000_AB60);
        checks++; if (lat !== 1 || !ak || !dr) begin errors++; $display("FAIL check_ack_width got lat %0d dropped %b exp 1/1", lat, dr); end
        checks++; if (io_out !== 16'hAB60) begin errors++; $display("FAIL check_ab60 got %h exp ab60", io_out); end
        bus(1'b1, BASE, 4'hF, 32'h0000_AB6A, rd, lat, ak, er, dr);
        m_write(BASE, 4'hF, 32'h0000_AB6A);
        checks++; if (io_out !== 16'hAB6A) begin errors++; $display("FAIL check_ab6a got %h exp ab6a", io_out); end
        bus(1'b1, BASE, 4'b0101, 32'hFFFF_1234, rd, lat, ak, er, dr);
        m_write(BASE, 4'b0101, 32'hFFFF_1234);
        bus(1'b0, BASE, 4'hF, 32'h0, rd, lat, ak, er, dr);
        checks++; if (rd !== m_read(BASE, 16'h0) || io_out !== m_check) begin errors++; $display("FAIL check_lanes got %h/%h exp %h", rd, io_out, m_check); end
    endtask

    task automatic test_scratch();
        logic [31:0] rd; int lat; logic ak, er, dr;
        bus(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, rd, lat, ak, er, dr);
        bus(1'b1, BASE + 32'h10, 4'b0001, 32'h0000_0055, rd, lat, ak, er, dr);
        m_write(BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
        m_write(BASE + 32'h10, 4'b0001, 32'h0000_0055);
        bus(1'b0, BASE + 32'h10, 4'hF, 32'h0, rd, lat, ak, er, dr);
        checks++; if (rd !== 32'hDEAD_BE55) begin errors++; $display("FAIL scratch1 got %h exp deadbe55", rd); end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) continue;
            bus(1'b0, BASE + 32'h0C + 32'(4*i), 4'hF, 32'h0, rd, lat, ak, er, dr);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL scratch%0d_zero got %h exp 0", i, rd); end
        end
    endtask

    task automatic test_padin();
        logic [31:0] rd; int lat; logic ak, er, dr;
        logic [15:0] old;
        old = io_in;
        @(negedge clk);
        io_in = 16'h1234;
        // First read samples the synchronizer on the second edge after the change.
        bus(1'b0, BASE + 32'h08, 4'hF, 32'h0, rd, lat, ak, er, dr);
        checks++; if (rd !== {16'h0, old}) begin errors++; $display("FAIL padin_latency got %h exp %h", rd, old); end
        bus(1'b0, BASE + 32'h08, 4'hF, 32'h0, rd, lat, ak, er, dr);
        checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL padin_value got %h exp 1234", rd); end
        bus(1'b1, BASE + 32'h08, 4'hF, 32'hFFFF, rd, lat, ak, er, dr);
        checks++; if (lat !== 1 || ak !== !m_err(1'b1, BASE + 32'h08) || er !== m_err(1'b1, BASE + 32'h08)) begin
            errors++; $display("FAIL padin_write_resp got lat %0d ack %b err %b", lat, ak, er); end
        bus(1'b0, BASE + 32'h08, 4'hF, 32'h0, rd, lat, ak, er, dr);
        checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL padin_ro got %h exp 1234", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        exp = m_read(BASE + 32'h10, 16'h0);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (ack !== logic'(i % 2) || rdat_o !== ((i % 2) ? exp : 32'h0)) begin
                errors++; $display("FAIL b2b_cycle%0d got ack %b data %h exp ack %0d", i, ack, rdat_o, i % 2);
            end
            @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(negedge clk);
        // Abort: strobe withdrawn before any clock edge sees it.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h04; sel = 4'hF; wdat = 32'h0;
        #2;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (ack !== 1'b0 || io_oeb !== m_oeb) begin errors++; $display("FAIL abort got ack %b oeb %h exp 0/%h", ack, io_oeb, m_oeb); end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; int lat; logic ak, er, dr;
        logic [31:0] addrs [2];
        addrs[0] = BASE + 32'h40;
        addrs[1] = 32'h3000_0104;
        foreach (addrs[k]) begin
            bus(1'b0, addrs[k], 4'hF, 32'h0, rd, lat, ak, er, dr);
            checks++;
            if (lat !== 1 || rd !== 32'h0 || ak !== !m_err(1'b0, addrs[k]) || er !== m_err(1'b0, addrs[k]) || !dr) begin
                errors++; $display("FAIL unmapped_%h got lat %0d data %h ack %b err %b", addrs[k], lat, rd, ak, er);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d; int lat; logic ak, er, dr, w; logic [3:0] s;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 11))
                0, 1, 2, 3, 4, 5, 6, 7, 8: a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                9:  a = BASE + 32'h20 + 32'($urandom_range(0, 55) * 4);
                10: a = 32'h3000_0100 + 32'($urandom_range(0, 7) * 4);
                default: a = 32'h2000_0000 + 32'($urandom_range(0, 7) * 4);
            endcase
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            bus(w, a, s, d, rd, lat, ak, er, dr);
            if (w && !m_err(w, a)) m_write(a, s, d);
            checks++;
            if (lat !== 1 || !dr || ak !== !m_err(w, a) || er !== m_err(w, a) ||
                (!w && rd !== (m_err(w, a) ? 32'h0 : m_read(a, io_in))) ||
                io_out !== m_check || io_oeb !== m_oeb) begin
                errors++;
                $display("FAIL random_%0d we %b adr %h got data %h ack %b err %b out %h oeb %h exp data %h out %h oeb %h",
                         n, w, a, rd, ak, er, io_out, io_oeb, m_read(a, io_in), m_check, m_oeb);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h0C; sel = 4'hF; wdat = 32'hCAFE_F00D;
        @(posedge clk); #2;
        rst = 1'b1;
        m_reset();
        #1;
        checks++; if (ack !== 1'b0 || io_out !== 16'h0 || io_oeb !== 16'hFFFF) begin
            errors++; $display("FAIL reset_mid got ack %b out %h oeb %h exp 0/0000/ffff", ack, io_out, io_oeb); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        begin
            logic [31:0] rd; int lat; logic ak, er, dr;
            bus(1'b0, BASE + 32'h0C, 4'hF, 32'h0, rd, lat, ak, er, dr);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mid_scratch got %h exp 0", rd); end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_check();
        test_scratch();
        test_padin();
        test_back_to_back();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
